pmem_write_buffer: RTL

//  Line-granular write-back buffer between the cache and physical memory.

---
 rtl/pmem_write_buffer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pmem_write_buffer.sv
// pmem_write_buffer: line-granular write-back buffer between cache and pmem.
// Evictions are queued in a small FIFO and drained when the cache is idle.
// Reads that hit a buffered line are answered from the buffer (youngest match).
// Optional feature macro: WB_BUF_COALESCE_EN (writes to a buffered line
// overwrite that entry in place instead of enqueueing a new one).
//
// state  | meaning
// IDLE   | arbitrate: read > write > drain
// RD_MEM | line fill from pmem in progress
// DRAIN  | writing head entry to pmem
// ACK    | one-cycle lmem_resp to the cache
module pmem_write_buffer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lmem_read,
  input  logic              lmem_write,
  input  logic [ADDR_W-1:0] lmem_address,
  input  logic [LINE_W-1:0] lmem_wdata,
  output logic [LINE_W-1:0] lmem_rdata,
  output logic              lmem_resp,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - 5;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_MEM, DRAIN, ACK} state_t;

  state_t            state, state_n;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head, tail, hit_idx;
  logic [CNT_W-1:0]  count;
  logic [LINE_W-1:0] rdata_q;
  logic              hit;
  logic              do_enq, do_ovw, do_pop, ld_hit, ld_mem;
  logic [TAG_W-1:0]  req_tag;
  logic [4:0]        unused_offset;

  assign req_tag       = lmem_address[ADDR_W-1:5];
  assign unused_offset = lmem_address[4:0];
  assign lmem_rdata    = rdata_q;

  // Tag lookup over valid entries, oldest to youngest so the youngest match wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (tag_q[head + PTR_W'(i)] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = head + PTR_W'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state, handshake outputs and datapath strobes.
  always_comb begin
    state_n      = state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    lmem_resp    = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    do_enq       = 1'b0;
    do_ovw       = 1'b0;
    do_pop       = 1'b0;
    ld_hit       = 1'b0;
    ld_mem       = 1'b0;
    case (state)
      IDLE: begin
        if (lmem_read) begin
          if (hit) begin
            ld_hit  = 1'b1;
            state_n = ACK;
          end else begin
            state_n = RD_MEM;
          end
        end else if (lmem_write) begin
`ifdef WB_BUF_COALESCE_EN
          if (hit) begin
            do_ovw  = 1'b1;
            state_n = ACK;
          end else if (count != FULL) begin
            do_enq  = 1'b1;
            state_n = ACK;
          end else begin
            state_n = DRAIN;
          end
`else
          if (count != FULL) begin
            do_enq  = 1'b1;
            state_n = ACK;
          end else begin
            state_n = DRAIN;
          end
`endif
        end else if (count != '0) begin
          state_n = DRAIN;
        end
      end
      RD_MEM: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, 5'b0};
        if (pmem_resp) begin
          ld_mem  = 1'b1;
          state_n = ACK;
        end
      end
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[head], 5'b0};
        pmem_wdata   = data_q[head];
        if (pmem_resp) begin
          do_pop  = 1'b1;
          state_n = IDLE;
        end
      end
      ACK: begin
        lmem_resp = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FIFO pointers, occupancy and the read-data return register.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rdata_q <= '0;
    end else begin
      if (do_enq) begin
        tail  <= tail + PTR_W'(1);
        count <= count + CNT_W'(1);
      end
      if (do_pop) begin
        head  <= head + PTR_W'(1);
        count <= count - CNT_W'(1);
      end
      if (ld_hit) rdata_q <= data_q[hit_idx];
      if (ld_mem) rdata_q <= pmem_rdata;
    end
  end

  // Entry storage; contents are only meaningful inside the head..tail window.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      tag_q[tail]  <= req_tag;
      data_q[tail] <= lmem_wdata;
    end else if (do_ovw) begin
      data_q[hit_idx] <= lmem_wdata;
    end
  end

endmodule
